fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_pkg.sv | 31 +++
 rtl/fetch_ctrl_row_unpacker.sv | 44 ++++
 rtl/fetch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and width helpers for the row fetch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fetch_state_t, default row/byte geometry, ROW_W/BYTE_W and matching width helpers.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    UNPACK    = 3'd3,
    DONE      = 3'd4
  } fetch_state_t;

  localparam int NUM_ROWS      = 9;
  localparam int BYTES_PER_ROW = 8;

  // Row counter must be able to hold NUM_ROWS itself (the "all rows done" value).
  function automatic int row_w(input int n_rows);
    return $clog2(n_rows + 1);
  endfunction

  // Byte counter width, never narrower than one bit.
  function automatic int byte_w(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

  localparam int ROW_W  = $clog2(NUM_ROWS + 1);
  localparam int BYTE_W = $clog2(BYTES_PER_ROW);

endpackage

// File: rtl/fetch_ctrl_row_unpacker.sv
// row_unpacker: holds one fetched word and emits it one byte per cycle, LSB byte first.
// Latency: byte 0 is presented the cycle after i_load; one byte per cycle while enabled.
// Backpressure: i_full stalls the shift and the byte counter, so no byte is dropped.
// Ports: i_load/i_word capture a word; i_en marks the unpack phase; i_full is the target FIFO's flag;
//        o_byte is the current byte, o_wr the write strobe, o_last marks the final byte of the word.
module row_unpacker #(
  parameter int DATA_WIDTH    = 8,
  parameter int BYTES_PER_ROW = 8,
  parameter int MEM_WIDTH     = 64,
  parameter int BYTE_W        = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [MEM_WIDTH-1:0]  i_word,
  input  logic                  i_en,
  input  logic                  i_full,
  output logic [DATA_WIDTH-1:0] o_byte,
  output logic                  o_wr,
  output logic                  o_last
);

  logic [MEM_WIDTH-1:0] r_shift;
  logic [BYTE_W-1:0]    r_cnt;

  assign o_byte = r_shift[DATA_WIDTH-1:0];
  assign o_wr   = i_en & ~i_full;
  assign o_last = (r_cnt == BYTE_W'(BYTES_PER_ROW - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
    end else if (o_wr) begin
      r_shift <= r_shift >> DATA_WIDTH;
      // Wrap explicitly so non-power-of-two byte counts restart cleanly.
      r_cnt   <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: issues one word read per row and unpacks each word byte-wise into that row's FIFO.
// Latency: per row 1 request cycle + memory latency + BYTES_PER_ROW write cycles; done pulses after the last row.
// Backpressure: i_mem_waitrequest holds the request stable; i_fifo_full[row] stalls unpacking without data loss.
// Ports: i_start/i_base_addr from the control FSM; o_mem_address/o_mem_read/i_mem_* form the Avalon-style read port;
//        o_fifo_wdata + one-hot o_fifo_wren drive the FIFO bank, i_fifo_full comes back; o_busy/o_done/o_err status.
// Optional: define FETCH_CTRL_TIMEOUT_EN to add a WAIT_DATA watchdog that re-issues the read and sets sticky o_err.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_ROWS       = 9,
  parameter int BYTES_PER_ROW  = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_read,
  input  logic [MEM_WIDTH-1:0]  i_mem_readdata,
  input  logic                  i_mem_readdatavalid,
  input  logic                  i_mem_waitrequest,
  output logic [DATA_WIDTH-1:0] o_fifo_wdata,
  output logic [NUM_ROWS-1:0]   o_fifo_wren,
  input  logic [NUM_ROWS-1:0]   i_fifo_full,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int RW = row_w(NUM_ROWS);
  localparam int BW = byte_w(BYTES_PER_ROW);

  if ((MEM_WIDTH != DATA_WIDTH * BYTES_PER_ROW) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("fetch_ctrl: MEM_WIDTH must equal DATA_WIDTH*BYTES_PER_ROW and TIMEOUT_CYCLES must be >= 1");
  end

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [RW-1:0]         r_row;
  logic [RW-1:0]         w_row_inc;
  logic [NUM_ROWS-1:0]   w_row_sel;
  logic                  w_full_sel;
  logic                  w_start_acc;
  logic                  w_load;
  logic                  w_wr;
  logic                  w_last;
  logic                  w_row_done;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_byte;

  // Row decode from the registered row counter only; in DONE the row equals
  // NUM_ROWS so no bit is selected, which keeps o_fifo_wren one-hot or zero.
  always_comb begin
    w_row_sel = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_row_sel[r] = (r_row == RW'(r));
    end
  end

  assign w_full_sel  = |(i_fifo_full & w_row_sel);
  assign w_start_acc = (r_state == IDLE) && i_start;
  assign w_load      = (r_state == WAIT_DATA) && i_mem_readdatavalid;
  assign w_row_inc   = r_row + RW'(1);
  assign w_row_done  = w_wr && w_last;

  row_unpacker #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTES_PER_ROW (BYTES_PER_ROW),
    .MEM_WIDTH     (MEM_WIDTH),
    .BYTE_W        (BW)
  ) u_unpacker (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_word  (i_mem_readdata),
    .i_en    (r_state == UNPACK),
    .i_full  (w_full_sel),
    .o_byte  (w_byte),
    .o_wr    (w_wr),
    .o_last  (w_last)
  );

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  // Counts cycles spent in WAIT_DATA; any other state clears it, so every
  // entry into WAIT_DATA starts from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state != WAIT_DATA) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == WAIT_DATA) && !i_mem_readdatavalid &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_base <= i_base_addr;
        r_row  <= '0;
      end else if (w_row_done) begin
        r_row <= w_row_inc;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_mem_read    = 1'b0;
    o_mem_address = '0;
    o_fifo_wren   = '0;
    o_fifo_wdata  = w_byte;
    o_busy        = (r_state != IDLE);
    o_done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = REQ;
      end
      REQ: begin
        o_mem_read    = 1'b1;
        // Address wraps modulo 2^ADDR_WIDTH by truncation.
        o_mem_address = r_base + ADDR_WIDTH'(r_row);
        if (!i_mem_waitrequest) w_state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (i_mem_readdatavalid) begin
          w_state_nxt = UNPACK;
        end else if (w_timeout) begin
          w_state_nxt = REQ;
        end
      end
      UNPACK: begin
        o_fifo_wren = w_wr ? w_row_sel : '0;
        if (w_row_done) begin
          w_state_nxt = (w_row_inc == RW'(NUM_ROWS)) ? DONE : REQ;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int DW  = 8;
  localparam int MW  = 64;
  localparam int AW  = 32;
  localparam int NR  = 9;
  localparam int BPR = 8;
  localparam int TO  = 64;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW-1:0] o_mem_address;
  logic          o_mem_read;
  logic [MW-1:0] i_mem_readdata = '0;
  logic          i_mem_readdatavalid = 1'b0;
  logic          i_mem_waitrequest = 1'b0;
  logic [DW-1:0] o_fifo_wdata;
  logic [NR-1:0] o_fifo_wren;
  logic [NR-1:0] i_fifo_full = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  fetch_ctrl #(
    .DATA_WIDTH(DW), .MEM_WIDTH(MW), .ADDR_WIDTH(AW),
    .NUM_ROWS(NR), .BYTES_PER_ROW(BPR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .o_mem_address(o_mem_address), .o_mem_read(o_mem_read),
    .i_mem_readdata(i_mem_readdata), .i_mem_readdatavalid(i_mem_readdatavalid),
    .i_mem_waitrequest(i_mem_waitrequest),
    .o_fifo_wdata(o_fifo_wdata), .o_fifo_wren(o_fifo_wren), .i_fifo_full(i_fifo_full),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // Memory and FIFO-bank behaviour knobs
  logic [31:0]   salt = 32'h1234_5678;
  int            rnd_pct = 0;
  int            rnd_lat_max = 0;
  logic [AW-1:0] stall_addr = '0;
  int            stall_left = 0;
  logic [AW-1:0] drop_addr = '0;
  int            drop_left = 0;
  int            bp_row = -1;
  int            bp_after = 0;
  int            bp_left = 0;
  logic          stray_rdv = 1'b0;
  logic          pend = 1'b0;
  int            pend_dly = 0;
  logic [MW-1:0] pend_dat = '0;

  // Observations
  logic [7:0]    got [NR][16];
  int            got_n [NR];
  logic [AW-1:0] acc_addr [32];
  int            acc_cyc [32];
  int            acc_n = 0;
  int            cyc = 0;
  int            wr_total = 0;
  int            stall_rd_cyc = 0;
  int            done_cnt = 0;
  int            done_busy_bad = 0;
  int            busy_cyc = 0;
  int            onehot_bad = 0;
  int            full_wr_bad = 0;
  int            full_cyc = 0;
  int            err_hi = 0;

  // Memory image: every word address holds a salted hash of itself.
  function automatic logic [MW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return {h ^ salt, a ^ ~salt};
  endfunction

  // Reference: FIFO r must hold exactly the bytes of word (base + r), LSB byte first.
  function automatic int data_errs(input logic [AW-1:0] base);
    int e;
    logic [MW-1:0] w;
    e = 0;
    for (int r = 0; r < NR; r++) begin
      w = mem_word(base + AW'(r));
      if (got_n[r] != BPR) e++;
      for (int b = 0; b < BPR && b < got_n[r] && b < 16; b++) begin
        if (got[r][b] !== w[8*b +: 8]) e++;
      end
    end
    return e;
  endfunction

  // Reference: exactly NR accepted reads, row r at (base + r) mod 2^AW.
  function automatic int addr_errs(input logic [AW-1:0] base);
    int e;
    e = (acc_n != NR) ? 1 : 0;
    for (int i = 0; i < NR && i < acc_n && i < 32; i++) begin
      if (acc_addr[i] !== base + AW'(i)) e++;
    end
    return e;
  endfunction

  // Memory responder / FIFO model / monitor: drive just after posedge, sample at negedge.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_mem_readdatavalid = 1'b0;
      if (stray_rdv) begin
        i_mem_readdatavalid = 1'b1;
        i_mem_readdata      = {2{32'hDEAD_BEEF}};
        stray_rdv           = 1'b0;
      end else if (pend) begin
        if (pend_dly == 0) begin
          i_mem_readdatavalid = 1'b1;
          i_mem_readdata      = pend_dat;
          pend                = 1'b0;
        end else begin
          pend_dly--;
        end
      end
      i_mem_waitrequest = 1'b0;
      if (o_mem_read && o_mem_address == stall_addr && stall_left > 0) begin
        i_mem_waitrequest = 1'b1;
        stall_left--;
      end else if (o_mem_read && $urandom_range(99) < rnd_pct) begin
        i_mem_waitrequest = 1'b1;
      end
      i_fifo_full = '0;
      for (int r = 0; r < NR; r++) begin
        if ($urandom_range(99) < rnd_pct) i_fifo_full[r] = 1'b1;
      end
      if (bp_row >= 0 && bp_left > 0 && got_n[bp_row] == bp_after) begin
        i_fifo_full[bp_row] = 1'b1;
        bp_left--;
      end

      @(negedge i_clk);
      cyc++;
      if (o_mem_read) begin
        if (o_mem_address == stall_addr) stall_rd_cyc++;
        if (!i_mem_waitrequest) begin
          if (acc_n < 32) begin
            acc_addr[acc_n] = o_mem_address;
            acc_cyc[acc_n]  = cyc;
          end
          acc_n++;
          if (drop_left > 0 && o_mem_address == drop_addr) begin
            drop_left--;
          end else begin
            pend     = 1'b1;
            pend_dly = (rnd_lat_max == 0) ? 0 : int'($urandom_range(rnd_lat_max));
            pend_dat = mem_word(o_mem_address);
          end
        end
      end
      if (o_fifo_wren != '0) begin
        if ((o_fifo_wren & (o_fifo_wren - 1'b1)) != '0) onehot_bad++;
        if ((o_fifo_wren & i_fifo_full) != '0) full_wr_bad++;
        for (int r = 0; r < NR; r++) begin
          if (o_fifo_wren[r]) begin
            if (got_n[r] < 16) got[r][got_n[r]] = o_fifo_wdata;
            got_n[r]++;
            wr_total++;
          end
        end
      end
      if (bp_row >= 0 && i_fifo_full[bp_row]) full_cyc++;
      if (o_done) begin
        done_cnt++;
        if (!o_busy) done_busy_bad++;
      end
      if (o_busy) busy_cyc++;
      if (o_err) err_hi++;
    end
  end

  task automatic clear_rec();
    for (int r = 0; r < NR; r++) got_n[r] = 0;
    acc_n = 0; wr_total = 0; stall_rd_cyc = 0; done_cnt = 0; done_busy_bad = 0;
    busy_cyc = 0; onehot_bad = 0; full_wr_bad = 0; full_cyc = 0;
    stall_left = 0; drop_left = 0; bp_row = -1; bp_left = 0; pend = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    @(posedge i_clk); #1;
    i_base_addr = base;
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge i_clk); #1;
      if (done_cnt > 0) ok = 1'b1;
    end
    repeat (3) @(negedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({o_mem_read, o_mem_address, o_fifo_wdata, o_fifo_wren, o_busy, o_done, o_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: busy=%0b read=%0b wren=%h, all must be 0", o_busy, o_mem_read, o_fifo_wren);
    end
    @(negedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    n_cmp++;
    if ({o_mem_read, o_busy, o_done, o_fifo_wren} !== '0) begin
      n_bad++; $display("FAIL reset_idle: busy=%0b read=%0b, expected 0 without start", o_busy, o_mem_read);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_rec(); rnd_pct = 0; rnd_lat_max = 0; salt = $urandom;
    pulse_start(32'h100);
    wait_done(3000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done_timeout: done not seen, required within budget"); end
    n_cmp++; if (addr_errs(32'h100) !== 0) begin n_bad++; $display("FAIL basic_addr: %0d address errors (acc=%0d), expected 0", addr_errs(32'h100), acc_n); end
    n_cmp++; if (data_errs(32'h100) !== 0) begin n_bad++; $display("FAIL basic_data: %0d byte errors, expected 0", data_errs(32'h100)); end
    n_cmp++; if (wr_total !== NR*BPR) begin n_bad++; $display("FAIL basic_writes: %0d writes, expected %0d", wr_total, NR*BPR); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_once: %0d done cycles, expected 1", done_cnt); end
    n_cmp++; if (busy_cyc !== NR*(2+BPR)+1) begin n_bad++; $display("FAIL basic_latency: busy %0d cycles, expected %0d", busy_cyc, NR*(2+BPR)+1); end
    n_cmp++; if (o_busy !== 1'b0 || done_busy_bad !== 0) begin n_bad++; $display("FAIL basic_busy: busy=%0b done_without_busy=%0d, expected 0/0", o_busy, done_busy_bad); end
    n_cmp++; if (onehot_bad !== 0) begin n_bad++; $display("FAIL basic_onehot: %0d multi-hot cycles, expected 0", onehot_bad); end
  endtask

  task automatic test_waitrequest();
    bit ok;
    logic [AW-1:0] b;
    clear_rec(); rnd_pct = 0; rnd_lat_max = 0; salt = $urandom;
    b = $urandom;
    stall_addr = b + AW'(2); stall_left = 3;
    pulse_start(b);
    wait_done(3000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wait_done_timeout: done not seen, required within budget"); end
    n_cmp++; if (stall_rd_cyc !== 4) begin n_bad++; $display("FAIL wait_hold: read held %0d cycles on row 2, expected 4", stall_rd_cyc); end
    n_cmp++; if (addr_errs(b) !== 0) begin n_bad++; $display("FAIL wait_addr: %0d errors (acc=%0d), expected 0", addr_errs(b), acc_n); end
    n_cmp++; if (data_errs(b) !== 0) begin n_bad++; $display("FAIL wait_data: %0d byte errors, expected 0", data_errs(b)); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [AW-1:0] b;
    clear_rec(); rnd_pct = 0; rnd_lat_max = 0; salt = $urandom;
    b = $urandom;
    bp_row = 4; bp_after = 3; bp_left = 5;
    pulse_start(b);
    wait_done(3000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_done_timeout: done not seen, required within budget"); end
    n_cmp++; if (full_cyc !== 5 || full_wr_bad !== 0) begin n_bad++; $display("FAIL bp_stall: full %0d cycles, writes while full %0d, expected 5/0", full_cyc, full_wr_bad); end
    n_cmp++; if (data_errs(b) !== 0) begin n_bad++; $display("FAIL bp_data: %0d byte errors (fifo4 got %0d), expected 0", data_errs(b), got_n[4]); end
    n_cmp++; if (busy_cyc !== NR*(2+BPR)+1+5) begin n_bad++; $display("FAIL bp_latency: busy %0d cycles, expected %0d", busy_cyc, NR*(2+BPR)+6); end
  endtask

  task automatic test_wrap_ignored();
    bit ok;
    int snap_busy, snap_wr, snap_acc;
    clear_rec(); rnd_pct = 20; rnd_lat_max = 3; salt = $urandom;
    pulse_start(32'hFFFF_FFFC);
    for (int i = 0; i < 500 && wr_total < 1; i++) begin
      @(negedge i_clk); #1;
    end
    pulse_start(32'h0000_5555);
    wait_done(5000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_done_timeout: done not seen, required within budget"); end
    n_cmp++; if (addr_errs(32'hFFFF_FFFC) !== 0) begin n_bad++; $display("FAIL wrap_addr: %0d errors (acc=%0d, first=%h), expected 0", addr_errs(32'hFFFF_FFFC), acc_n, acc_addr[0]); end
    n_cmp++; if (data_errs(32'hFFFF_FFFC) !== 0) begin n_bad++; $display("FAIL wrap_data: %0d byte errors, expected 0", data_errs(32'hFFFF_FFFC)); end
    n_cmp++; if (done_cnt !== 1 || full_wr_bad !== 0 || onehot_bad !== 0) begin n_bad++; $display("FAIL wrap_flags: done=%0d fullwr=%0d multihot=%0d, expected 1/0/0", done_cnt, full_wr_bad, onehot_bad); end
    rnd_pct = 0;
    snap_busy = busy_cyc; snap_wr = wr_total; snap_acc = acc_n;
    stray_rdv = 1'b1;
    repeat (6) @(negedge i_clk);
    #1;
    n_cmp++;
    if ((busy_cyc - snap_busy) !== 0 || (wr_total - snap_wr) !== 0 || (acc_n - snap_acc) !== 0) begin
      n_bad++; $display("FAIL stray_rdv: busy+%0d writes+%0d reads+%0d after idle readdatavalid, expected 0", busy_cyc - snap_busy, wr_total - snap_wr, acc_n - snap_acc);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [AW-1:0] b;
    for (int it = 0; it < 3; it++) begin
      clear_rec(); rnd_pct = $urandom_range(40); rnd_lat_max = $urandom_range(4); salt = $urandom;
      b = $urandom;
      pulse_start(b);
      wait_done(6000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_done_timeout: done not seen, required within budget", it); end
      n_cmp++; if (addr_errs(b) !== 0) begin n_bad++; $display("FAIL rand%0d_addr: %0d errors, expected 0", it, addr_errs(b)); end
      n_cmp++; if (data_errs(b) !== 0 || full_wr_bad !== 0) begin n_bad++; $display("FAIL rand%0d_data: %0d byte errors, %0d writes while full, expected 0/0", it, data_errs(b), full_wr_bad); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [AW-1:0] b;
    clear_rec(); rnd_pct = 0; rnd_lat_max = 0; salt = $urandom;
    pulse_start($urandom);
    for (int i = 0; i < 1000 && got_n[3] < 3; i++) begin
      @(negedge i_clk); #1;
    end
    n_cmp++; if (got_n[3] < 3) begin n_bad++; $display("FAIL rstmid_reach: row3 writes %0d, expected >=3 before reset", got_n[3]); end
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_mem_read, o_mem_address, o_fifo_wdata, o_fifo_wren, o_busy, o_done, o_err} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: busy=%0b wren=%h wdata=%h, all must be 0", o_busy, o_fifo_wren, o_fifo_wdata);
    end
    repeat (2) @(negedge i_clk);
    #1;
    clear_rec();
    i_rst_n = 1'b1;
    b = $urandom;
    pulse_start(b);
    wait_done(3000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_done_timeout: done not seen, required within budget"); end
    n_cmp++; if (addr_errs(b) !== 0 || data_errs(b) !== 0) begin n_bad++; $display("FAIL rstmid_refetch: addr errs %0d data errs %0d, expected 0/0", addr_errs(b), data_errs(b)); end
  endtask

  task automatic test_err_quiet();
    n_cmp++;
    if (err_hi !== 0) begin n_bad++; $display("FAIL err_quiet: err high %0d cycles without any timeout, expected 0", err_hi); end
  endtask

`ifdef FETCH_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    logic [AW-1:0] b;
    clear_rec(); rnd_pct = 0; rnd_lat_max = 0; salt = $urandom;
    b = $urandom;
    drop_addr = b + AW'(1); drop_left = 1;
    pulse_start(b);
    wait_done(3000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_done_timeout: done not seen, required within budget"); end
    n_cmp++; if (acc_n !== NR+1 || acc_addr[1] !== b + AW'(1) || acc_addr[2] !== b + AW'(1)) begin
      n_bad++; $display("FAIL to_reissue: reads=%0d a1=%h a2=%h, expected %0d and %h twice", acc_n, acc_addr[1], acc_addr[2], NR+1, b + AW'(1));
    end
    n_cmp++; if (acc_cyc[2] - acc_cyc[1] !== TO+1) begin n_bad++; $display("FAIL to_gap: reissue after %0d cycles, expected %0d", acc_cyc[2] - acc_cyc[1], TO+1); end
    n_cmp++; if (data_errs(b) !== 0 || done_cnt !== 1) begin n_bad++; $display("FAIL to_data: %0d byte errors done=%0d, expected 0/1", data_errs(b), done_cnt); end
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky: err=%0b, expected 1", o_err); end
    clear_rec();
    pulse_start(b);
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL to_err_clear: err=%0b after new start, expected 0", o_err); end
    wait_done(3000, ok);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < NR; r++) got_n[r] = 0;
    test_reset();
    test_basic();
    test_waitrequest();
    test_backpressure();
    test_wrap_ignored();
    test_random();
    test_reset_mid();
    test_err_quiet();
`ifdef FETCH_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
